// File: rtl/s_axis_seq_checker.sv
// AXI4-Stream sink that checks an incrementing word stream for gaps and
// ordering, with a programmable tready throttle and first-error capture.
module s_axis_seq_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int ERR_WIDTH      = 16,
  parameter int ACCEPT_RESTART = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [7:0]            ready_mask,
  output logic                  locked,
  output logic [31:0]           beat_count,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic                  err_flag,
  output logic [DATA_WIDTH-1:0] err_expected,
  output logic [DATA_WIDTH-1:0] err_received,
  output logic [1:0]            dbg_state
);

  // Handshake: a beat transfers on a rising edge where tvalid and tready are
  // both high. tready is a registered function of enable, clear, ready_mask
  // and the throttle phase only; it never looks at tvalid.

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SEEK     = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [2:0]            phase;
  logic [2:0]            phase_next;
  logic                  hs;
  logic                  beat;
  logic                  seq_ok;
  logic [DATA_WIDTH-1:0] expected;

  assign dbg_state = state;

  always_comb begin
    phase_next = 3'd0;
    if (enable && !clear) phase_next = phase + 3'd1;
    hs   = s_axis_tvalid & s_axis_tready;
    // A cleared or disabled cycle never consumes a beat into the counters.
    beat = hs & enable & ~clear;
    seq_ok = (s_axis_tdata == expected) ||
             ((ACCEPT_RESTART != 0) && (s_axis_tdata == '0));
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_DISABLED;
    end else if (clear) begin
      state_next = ST_SEEK;
    end else begin
      case (state)
        ST_DISABLED: state_next = ST_SEEK;
        ST_SEEK:     if (hs) state_next = ST_LOCKED;
        ST_LOCKED:   state_next = ST_LOCKED;
        default:     state_next = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_DISABLED;
      phase         <= 3'd0;
      s_axis_tready <= 1'b0;
      expected      <= '0;
      locked        <= 1'b0;
      beat_count    <= 32'd0;
      error_count   <= '0;
      err_flag      <= 1'b0;
      err_expected  <= '0;
      err_received  <= '0;
    end else begin
      state         <= state_next;
      phase         <= phase_next;
      s_axis_tready <= enable & ~clear & ready_mask[phase_next];
      if (clear) begin
        locked       <= 1'b0;
        beat_count   <= 32'd0;
        error_count  <= '0;
        err_flag     <= 1'b0;
        err_expected <= '0;
        err_received <= '0;
      end else if (!enable) begin
        locked <= 1'b0;
      end else if (beat && (state == ST_SEEK)) begin
        beat_count <= beat_count + 32'd1;
        expected   <= s_axis_tdata + DATA_WIDTH'(1);
        locked     <= 1'b1;
      end else if (beat && (state == ST_LOCKED)) begin
        beat_count <= beat_count + 32'd1;
        // Resync to the received value so one gap costs exactly one error.
        expected   <= s_axis_tdata + DATA_WIDTH'(1);
        if (!seq_ok) begin
          if (error_count != '1) error_count <= error_count + ERR_WIDTH'(1);
          if (!err_flag) begin
            err_flag     <= 1'b1;
            err_expected <= expected;
            err_received <= s_axis_tdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_s_axis_seq_checker.sv
// Directed bench for s_axis_seq_checker: a cycle table plus hand-written
// sequences for streaming, throttle restart, saturation and mid-stream reset.
module tb_s_axis_seq_checker;

  localparam logic [1:0] S_DIS  = 2'd0;
  localparam logic [1:0] S_SEEK = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] tdata;
  logic        tvalid;
  logic        enable;
  logic        clear;
  logic [7:0]  ready_mask;

  logic        rdy0, lock0, flag0;
  logic [31:0] bc0, exp0, rcv0;
  logic [15:0] ec0;
  logic [1:0]  st0;
  logic        rdy1, lock1, flag1;
  logic [31:0] bc1, exp1, rcv1;
  logic [3:0]  ec1;
  logic [1:0]  st1;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] src_data;

  always #5 aclk = ~aclk;

  s_axis_seq_checker #(.DATA_WIDTH(32), .ERR_WIDTH(16), .ACCEPT_RESTART(1)) dut0 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(rdy0), .enable(enable), .clear(clear), .ready_mask(ready_mask),
    .locked(lock0), .beat_count(bc0), .error_count(ec0), .err_flag(flag0),
    .err_expected(exp0), .err_received(rcv0), .dbg_state(st0)
  );

  s_axis_seq_checker #(.DATA_WIDTH(32), .ERR_WIDTH(4), .ACCEPT_RESTART(0)) dut1 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(rdy1), .enable(enable), .clear(clear), .ready_mask(ready_mask),
    .locked(lock1), .beat_count(bc1), .error_count(ec1), .err_flag(flag1),
    .err_expected(exp1), .err_received(rcv1), .dbg_state(st1)
  );

  typedef struct {
    logic        en;
    logic        clr;
    logic        valid;
    logic [31:0] data;
    logic        e_rdy;
    logic        e_lock;
    logic [31:0] e_bc;
    logic [15:0] e_ec;
    logic        e_flag;
    logic [31:0] e_exp;
    logic [31:0] e_rcv;
    logic [1:0]  e_st;
    logic [3:0]  e_ec1;
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(logic en, logic clr, logic valid, logic [31:0] data,
                              logic e_rdy, logic e_lock, logic [31:0] e_bc,
                              logic [15:0] e_ec, logic e_flag, logic [31:0] e_exp,
                              logic [31:0] e_rcv, logic [1:0] e_st, logic [3:0] e_ec1);
    vec_t v;
    v.en = en; v.clr = clr; v.valid = valid; v.data = data;
    v.e_rdy = e_rdy; v.e_lock = e_lock; v.e_bc = e_bc; v.e_ec = e_ec;
    v.e_flag = e_flag; v.e_exp = e_exp; v.e_rcv = e_rcv; v.e_st = e_st;
    v.e_ec1 = e_ec1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Counter-style source: advances on each accepted beat; with restart set it
  // goes back to 0 after any cycle where tready was low.
  task automatic stream(input int n_beats, input int max_cyc, input bit counting,
                        input bit restart, output int hs_n);
    logic took;
    hs_n = 0;
    for (int c = 0; c < max_cyc && hs_n < n_beats; c++) begin
      tvalid = 1'b1;
      tdata  = src_data;
      took   = rdy0;
      step();
      if (took) begin
        hs_n++;
        if (counting) src_data = src_data + 32'd1;
      end else if (restart) begin
        src_data = 32'd0;
      end
    end
    if (hs_n < n_beats) begin
      n_vec++;
      n_fail++;
      $display("FAIL stream_timeout: got %0d beats want %0d", hs_n, n_beats);
    end
  endtask

  task automatic pulse_clear();
    tvalid = 1'b0;
    clear  = 1'b1;
    step();
    clear  = 1'b0;
  endtask

  initial begin
    int hs_n;
    // en clr vld data | rdy lock bc ec flag exp rcv st ec1
    vt[0]  = mk(1, 0, 0, 32'd0,  1, 0, 0, 0, 0, 0, 0, S_SEEK, 0);
    vt[1]  = mk(1, 0, 1, 32'd5,  1, 1, 1, 0, 0, 0, 0, S_LOCK, 0);
    vt[2]  = mk(1, 0, 1, 32'd6,  1, 1, 2, 0, 0, 0, 0, S_LOCK, 0);
    vt[3]  = mk(1, 0, 1, 32'd9,  1, 1, 3, 1, 1, 7, 9, S_LOCK, 1);
    vt[4]  = mk(1, 0, 1, 32'd10, 1, 1, 4, 1, 1, 7, 9, S_LOCK, 1);
    vt[5]  = mk(1, 0, 1, 32'd20, 1, 1, 5, 2, 1, 7, 9, S_LOCK, 2);
    vt[6]  = mk(1, 0, 1, 32'd21, 1, 1, 6, 2, 1, 7, 9, S_LOCK, 2);
    vt[7]  = mk(1, 0, 1, 32'd0,  1, 1, 7, 2, 1, 7, 9, S_LOCK, 3);
    vt[8]  = mk(1, 0, 1, 32'd1,  1, 1, 8, 2, 1, 7, 9, S_LOCK, 3);
    vt[9]  = mk(1, 1, 1, 32'd2,  0, 0, 0, 0, 0, 0, 0, S_SEEK, 0);
    vt[10] = mk(1, 0, 1, 32'd2,  1, 0, 0, 0, 0, 0, 0, S_SEEK, 0);
    vt[11] = mk(1, 0, 1, 32'd2,  1, 1, 1, 0, 0, 0, 0, S_LOCK, 0);
    vt[12] = mk(1, 0, 1, 32'd3,  1, 1, 2, 0, 0, 0, 0, S_LOCK, 0);
    vt[13] = mk(0, 0, 0, 32'd4,  0, 0, 2, 0, 0, 0, 0, S_DIS,  0);
    vt[14] = mk(1, 0, 1, 32'd4,  1, 0, 2, 0, 0, 0, 0, S_SEEK, 0);
    vt[15] = mk(1, 0, 1, 32'd100, 1, 1, 3, 0, 0, 0, 0, S_LOCK, 0);
    vt[16] = mk(1, 1, 0, 32'd0,  0, 0, 0, 0, 0, 0, 0, S_SEEK, 0);
    vt[17] = mk(1, 0, 0, 32'd0,  1, 0, 0, 0, 0, 0, 0, S_SEEK, 0);
    vt[18] = mk(1, 0, 1, 32'hFFFF_FFFE, 1, 1, 1, 0, 0, 0, 0, S_LOCK, 0);
    vt[19] = mk(1, 0, 1, 32'hFFFF_FFFF, 1, 1, 2, 0, 0, 0, 0, S_LOCK, 0);
    vt[20] = mk(1, 0, 1, 32'h0000_0000, 1, 1, 3, 0, 0, 0, 0, S_LOCK, 0);
    vt[21] = mk(1, 0, 1, 32'h0000_0001, 1, 1, 4, 0, 0, 0, 0, S_LOCK, 0);

    areset = 1'b1; tdata = '0; tvalid = 1'b0; enable = 1'b0; clear = 1'b0;
    ready_mask = 8'hFF; src_data = '0;
    step(); step();
    areset = 1'b0;
    check("rst_tready", rdy0, 0);
    check("rst_locked", lock0, 0);
    check("rst_beat_count", bc0, 0);
    check("rst_error_count", ec0, 0);
    check("rst_err_flag", flag0, 0);
    check("rst_err_expected", exp0, 0);
    check("rst_err_received", rcv0, 0);
    check("rst_state", st0, S_DIS);

    for (int i = 0; i < 22; i++) begin
      enable = vt[i].en; clear = vt[i].clr; tvalid = vt[i].valid; tdata = vt[i].data;
      step();
      check($sformatf("v%0d_tready", i), rdy0, vt[i].e_rdy);
      check($sformatf("v%0d_locked", i), lock0, vt[i].e_lock);
      check($sformatf("v%0d_beat_count", i), bc0, vt[i].e_bc);
      check($sformatf("v%0d_error_count", i), ec0, vt[i].e_ec);
      check($sformatf("v%0d_err_flag", i), flag0, vt[i].e_flag);
      check($sformatf("v%0d_err_expected", i), exp0, vt[i].e_exp);
      check($sformatf("v%0d_err_received", i), rcv0, vt[i].e_rcv);
      check($sformatf("v%0d_state", i), st0, vt[i].e_st);
      check($sformatf("v%0d_norestart_error_count", i), ec1, vt[i].e_ec1);
    end
    clear = 1'b0; enable = 1'b1;

    // 100 beats of 1,2,3,... with continuous ready.
    ready_mask = 8'hFF;
    pulse_clear();
    src_data = 32'd1;
    stream(100, 300, 1'b1, 1'b0, hs_n);
    tvalid = 1'b0;
    step();
    check("cont_locked", lock0, 1);
    check("cont_beat_count", bc0, 100);
    check("cont_error_count", ec0, 0);
    check("cont_err_flag", flag0, 0);
    check("cont_norestart_error_count", ec1, 0);

    // Alternating ready: the source restarts at 0 after every stall.
    ready_mask = 8'b0101_0101;
    pulse_clear();
    src_data = 32'd0;
    for (int k = 0; k < 24; k++) begin
      logic took;
      tvalid = 1'b1;
      tdata  = src_data;
      took   = rdy0;
      step();
      if (took) src_data = src_data + 32'd1;
      else      src_data = 32'd0;
      check($sformatf("restart_tready_%0d", k), rdy0, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    tvalid = 1'b0;
    step();
    check("restart_beat_count", bc0, 11);
    check("restart_error_count", ec0, 0);
    check("restart_norestart_beat_count", bc1, 11);
    check("restart_norestart_error_count", ec1, 10);

    // Constant data forces a mismatch on every beat after the seed.
    ready_mask = 8'hFF;
    pulse_clear();
    src_data = 32'd5;
    stream(65545, 65600, 1'b0, 1'b0, hs_n);
    check("sat_beat_count", bc0, 65545);
    check("sat_error_count", ec0, 32'h0000_FFFF);
    check("sat_err_flag", flag0, 1);
    check("sat_err_expected", exp0, 6);
    check("sat_err_received", rcv0, 5);
    check("sat_small_error_count", ec1, 15);

    // Clear in the same cycle as a handshake: the beat is dropped.
    check("clrhs_pre_tready", rdy0, 1);
    tvalid = 1'b1; tdata = 32'd5; clear = 1'b1;
    step();
    clear = 1'b0;
    check("clrhs_beat_count", bc0, 0);
    check("clrhs_error_count", ec0, 0);
    check("clrhs_err_flag", flag0, 0);
    check("clrhs_locked", lock0, 0);
    check("clrhs_state", st0, S_SEEK);
    check("clrhs_small_error_count", ec1, 0);

    // Reset in the middle of a stream with tvalid held high.
    src_data = 32'd10;
    stream(5, 20, 1'b1, 1'b0, hs_n);
    tvalid = 1'b1; tdata = src_data; areset = 1'b1;
    step();
    areset = 1'b0;
    check("mrst_tready", rdy0, 0);
    check("mrst_locked", lock0, 0);
    check("mrst_beat_count", bc0, 0);
    check("mrst_error_count", ec0, 0);
    check("mrst_err_flag", flag0, 0);
    check("mrst_err_expected", exp0, 0);
    check("mrst_err_received", rcv0, 0);
    check("mrst_state", st0, S_DIS);
    src_data = 32'd50;
    stream(1, 10, 1'b1, 1'b0, hs_n);
    tvalid = 1'b0;
    step();
    check("reseed_locked", lock0, 1);
    check("reseed_beat_count", bc0, 1);
    check("reseed_error_count", ec0, 0);
    check("reseed_err_flag", flag0, 0);
    check("reseed_state", st0, S_LOCK);
    check("reseed_small_error_count", ec1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
